// File: rtl/playseq_condiciona_entradas.sv
// Synchronizes, debounces and one-hot-qualifies the PlaySeq push buttons and start key.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES filter cycles from raw capture to registered outputs.
// Backpressure: none; event pulses last one cycle and the consumer samples them every cycle.
module playseq_condiciona_entradas #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes_raw,
  input  logic       jogar_raw,
  output logic [3:0] botoes,
  output logic       jogada_pulso,
  output logic       jogar,
  output logic       multiplo,
  output logic [1:0] db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int JW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CONT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [JW-1:0] JCONT_MAX = JW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    FILTRANDO   = 2'd1,
    PRESSIONADO = 2'd2,
    SOLTANDO    = 2'd3
  } estado_t;

  typedef enum logic {
    SOLTO    = 1'b0,
    APERTADO = 1'b1
  } filtro_t;

  logic [3:0]    bot_m, s_bot;
  logic          jog_m, s_jog;

  estado_t       estado, estado_nx;
  logic [3:0]    amostra, amostra_nx;
  logic [CW-1:0] cont, cont_nx;
  logic [3:0]    botoes_nx;
  logic          multiplo_nx, pulso_nx;

  filtro_t       jog_estado, jog_estado_nx;
  logic [JW-1:0] jcont, jcont_nx;
  logic          jogar_nx, jog_contrario;

  // Two-flop synchronizers for every raw board input.
  always_ff @(posedge clock) begin
    if (!reset) begin
      bot_m <= '0;
      s_bot <= '0;
      jog_m <= 1'b0;
      s_jog <= 1'b0;
    end else begin
      bot_m <= botoes_raw;
      s_bot <= bot_m;
      jog_m <= jogar_raw;
      s_jog <= jog_m;
    end
  end

  // Button-group next state: filter a stable non-zero pattern, then hold until a stable release.
  always_comb begin
    estado_nx   = estado;
    amostra_nx  = amostra;
    cont_nx     = cont;
    botoes_nx   = botoes;
    multiplo_nx = multiplo;
    pulso_nx    = 1'b0;
    case (estado)
      OCIOSO: begin
        if (s_bot != 4'd0) begin
          estado_nx  = FILTRANDO;
          amostra_nx = s_bot;
          cont_nx    = '0;
        end
      end
      FILTRANDO: begin
        if (s_bot == 4'd0) begin
          estado_nx = OCIOSO;
        end else if (s_bot != amostra) begin
          amostra_nx = s_bot;
          cont_nx    = '0;
        end else if (cont == CONT_MAX) begin
          estado_nx = PRESSIONADO;
          // A pattern with exactly one bit set is a legal play; anything else is flagged.
          if ((amostra & (amostra - 4'd1)) == 4'd0) begin
            botoes_nx = amostra;
            pulso_nx  = 1'b1;
          end else begin
            botoes_nx   = 4'd0;
            multiplo_nx = 1'b1;
          end
        end else begin
          cont_nx = cont + 1'b1;
        end
      end
      PRESSIONADO: begin
        if (s_bot == 4'd0) begin
          estado_nx = SOLTANDO;
          cont_nx   = '0;
        end
      end
      SOLTANDO: begin
        if (s_bot != 4'd0) begin
          estado_nx = PRESSIONADO;
        end else if (cont == CONT_MAX) begin
          estado_nx   = OCIOSO;
          botoes_nx   = 4'd0;
          multiplo_nx = 1'b0;
        end else begin
          cont_nx = cont + 1'b1;
        end
      end
      default: estado_nx = OCIOSO;
    endcase
  end

  // Button-group registers; reset parks in SOLTANDO so a held button cannot fire after reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado       <= SOLTANDO;
      amostra      <= '0;
      cont         <= '0;
      botoes       <= '0;
      multiplo     <= 1'b0;
      jogada_pulso <= 1'b0;
    end else begin
      estado       <= estado_nx;
      amostra      <= amostra_nx;
      cont         <= cont_nx;
      botoes       <= botoes_nx;
      multiplo     <= multiplo_nx;
      jogada_pulso <= pulso_nx;
    end
  end

  // Start filter: count contrary samples and flip only after a full run, so its latency matches the buttons.
  always_comb begin
    jog_estado_nx = jog_estado;
    jcont_nx      = jcont;
    jogar_nx      = 1'b0;
    jog_contrario = (s_jog != (jog_estado == APERTADO));
    if (!jog_contrario) begin
      jcont_nx = '0;
    end else if (jcont == JCONT_MAX) begin
      jcont_nx      = '0;
      jog_estado_nx = (jog_estado == SOLTO) ? APERTADO : SOLTO;
      jogar_nx      = (jog_estado == SOLTO);
    end else begin
      jcont_nx = jcont + 1'b1;
    end
  end

  // Start filter registers; reset assumes the key is held so it must be seen released first.
  always_ff @(posedge clock) begin
    if (!reset) begin
      jog_estado <= APERTADO;
      jcont      <= '0;
      jogar      <= 1'b0;
    end else begin
      jog_estado <= jog_estado_nx;
      jcont      <= jcont_nx;
      jogar      <= jogar_nx;
    end
  end

  assign db_estado = estado;

endmodule

// File: doc/playseq_condiciona_entradas.md
# playseq_condiciona_entradas

Input-conditioning stage sitting directly upstream of the PlaySeq game top. It takes raw asynchronous push-button levels from the board and synchronizes and debounces them. It delivers clean `botoes` and `jogar` signals plus single-cycle event pulses to the game circuit. It also rejects multi-button presses and ignores inputs that are held across reset, so the game sees only deliberate, one-hot plays.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable samples required to accept a level change (1 ms at 50 MHz). Legal range is 2 to 2^20.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low. Asserted when 0 at a rising edge.
- `botoes_raw`  in  4  raw button levels, asynchronous, 1 = pressed.
- `jogar_raw`  in  1  raw start-button level, asynchronous, 1 = pressed.
- `botoes`  out  4  debounced one-hot play, held while the button stays pressed. Drives the game's `botoes` input.
- `jogada_pulso`  out  1  one-cycle pulse when a one-hot press is accepted.
- `jogar`  out  1  one-cycle pulse on the debounced rising edge of the start button. Drives the game's `jogar` input.
- `multiplo`  out  1  high while an accepted press has more than one bit set. In that case `botoes` stays 0.
- `db_estado`  out  2  button-group FSM state: 0 OCIOSO, 1 FILTRANDO, 2 PRESSIONADO, 3 SOLTANDO.

## Operation
- **Synchronizers.** Every raw input passes through a 2-flop synchronizer. Call the synchronized outputs `s_bot` and `s_jog`. All filtering uses these outputs only.
- **Button-group FSM.** It has a sample register `amostra[3:0]` and a counter `cont`, sized ceil(log2(DEBOUNCE_CYCLES)) bits.
  - **OCIOSO:** if `s_bot`≠0, go to FILTRANDO with `amostra`=`s_bot` and `cont`=0.
  - **FILTRANDO:**
    - If `s_bot`=0, go to OCIOSO.
    - Else if `s_bot`≠`amostra`, reload `amostra`=`s_bot` and `cont`=0, staying in FILTRANDO.
    - Else if `cont`=DEBOUNCE_CYCLES−1, accept the press and go to PRESSIONADO:
      - If `amostra` is one-hot: `botoes`←`amostra`, `jogada_pulso`=1 for one cycle.
      - Otherwise: `botoes`←0, `multiplo`←1, no pulse.
    - Otherwise `cont`++.
  - **PRESSIONADO:** outputs are held. If `s_bot`=0, go to SOLTANDO with `cont`=0. Bits added or changed while held are ignored.
  - **SOLTANDO:**
    - If `s_bot`≠0, return to PRESSIONADO with outputs unchanged.
    - Else if `cont`=DEBOUNCE_CYCLES−1, go to OCIOSO with `botoes`←0 and `multiplo`←0.
    - Otherwise `cont`++.
- **Start filter.** This is an independent 2-state filter (SOLTO/APERTADO) with its own counter.
  - The level changes only after DEBOUNCE_CYCLES consecutive samples of the opposite value. Any contrary sample resets the counter.
  - `jogar` pulses for one cycle on each SOLTO→APERTADO transition only.
- **Reset.**
  - Synchronizers, `amostra`, and both counters clear.
  - Outputs `botoes`=0, `jogada_pulso`=0, `jogar`=0, `multiplo`=0, `db_estado`=3.
  - The button FSM enters SOLTANDO and the start filter enters APERTADO. Inputs held through reset must therefore read 0 for DEBOUNCE_CYCLES samples before any new press can be accepted. No spurious play or start follows reset.
- **Reset mid-operation** aborts any filtering in progress and applies the reset values on the same edge. No pulse is emitted on that edge.

## Timing
- Let E0 be the rising edge that first captures a new raw level into the first synchronizer flop. `s_bot` shows the value after E0+1.
- The FSM enters FILTRANDO at E0+2.
- If the raw input stays stable, acceptance happens at edge E0+2+DEBOUNCE_CYCLES. At that edge `botoes`, `multiplo`, and `jogada_pulso` update.
- `jogada_pulso` is high for exactly the one cycle following that edge.
- Release latency is the same: `botoes` clears at edge E0'+2+DEBOUNCE_CYCLES after the release is captured.
- `jogar` follows the same latency, counted from its own E0.
- All outputs are registered. There is no combinational path from input to output.
- Button and start events are independent and may pulse in the same cycle.
- No handshake is required. The consumer samples pulses every cycle.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Clean press:** after reset and 6 idle cycles, hold `botoes_raw`=0010 for 20 cycles. Require `jogada_pulso` for exactly one cycle 6 edges after capture, and `botoes`=0010 from that edge. After release, `botoes`=0000 6 edges after the release is captured.
- **Bounce:** toggle 0100/0000 every 2 cycles for 10 cycles, then hold 0100. Require no pulse during the toggling, then exactly one pulse 6 edges after the last 0→0100 capture.
- **Multi-press:** hold 0011 for 10 cycles. Require `multiplo`=1, `botoes`=0000, and no `jogada_pulso`. After release, `multiplo` returns to 0.
- **Release glitch:** hold 1000 until accepted, drop to 0 for 2 cycles, then return to 1000. Require `botoes` to stay 1000 with no second pulse.
- **Held through reset:** with `jogar_raw`=1 and `botoes_raw`=0001 held, pulse `reset`=0 for 1 cycle and keep the inputs high for 10 more cycles. Require `jogar` and `jogada_pulso` to stay 0. Release, then press again; require one normal pulse each.
- **Simultaneous events:** press `jogar_raw` and 0001 on the same edge. Require `jogar` and `jogada_pulso` to pulse in the same cycle, 6 edges later.
